// File: rtl/alu_const_select_sequencer.sv
// Drives one-hot ALU constant-mux selects for HOLD_CYCLES per request (DAA: CMP_LATENCY of 0x99, then correction).
// Latency accept->Done: HOLD_CYCLES+1 (DAA: CMP_LATENCY+HOLD_CYCLES+1); Req_Ready only in IDLE, requester holds Req_Valid.
module alu_const_select_sequencer #(
    parameter int HOLD_CYCLES = 1,
    parameter int CMP_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic [2:0]  Req_Kind,
    input  logic [2:0]  Req_Index,
    input  logic        Flag_H,
    input  logic        Flag_C,
    input  logic        Low_Nib_Gt9,
    input  logic        Alu_Gt99,
    output logic [17:0] Sel,
    output logic        Done,
    output logic        Daa_Carry
);

    typedef enum logic [2:0] {IDLE, DRIVE, DAA_CMP, DAA_DRIVE, DONE} state_t;

    localparam logic [2:0] K_INC     = 3'd1;
    localparam logic [2:0] K_BITMASK = 3'd2;
    localparam logic [2:0] K_RST     = 3'd3;
    localparam logic [2:0] K_DAA     = 3'd4;
    localparam logic [2:0] K_FFOP    = 3'd5;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] CMP_LOAD  = 4'(CMP_LATENCY - 1);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [17:0] r_sel, w_sel_nxt;
    logic        r_done, w_done_nxt;
    logic        r_daa_carry, w_carry_nxt;
    logic        r_lo, w_lo_nxt;
    logic        r_flag_c, w_flag_c_nxt;
    logic        r_hi, w_hi_nxt;

    logic [17:0] w_decode;
    logic [17:0] w_daa_sel;
    logic [4:0]  w_rst_bit;
    logic        w_hi_now;

    assign Req_Ready = (r_state == IDLE) && RESET_n;
    assign Sel       = r_sel;
    assign Done      = r_done;
    assign Daa_Carry = r_daa_carry;

    // RST vector n*8 sits on Sel[n+2] for n = 1..7
    assign w_rst_bit = {2'b00, Req_Index} + 5'd2;
    assign w_hi_now  = r_flag_c | Alu_Gt99;

    always_comb begin
        w_decode = '0;
        case (Req_Kind)
            K_INC:  w_decode[2] = 1'b1;
            K_FFOP: w_decode[1] = 1'b1;
            K_BITMASK: begin
                case (Req_Index)
                    3'd0: w_decode[2]  = 1'b1;
                    3'd1: w_decode[14] = 1'b1;
                    3'd2: w_decode[15] = 1'b1;
                    3'd3: w_decode[3]  = 1'b1;
                    3'd4: w_decode[4]  = 1'b1;
                    3'd5: w_decode[6]  = 1'b1;
                    3'd6: w_decode[16] = 1'b1;
                    default: w_decode[17] = 1'b1;
                endcase
            end
            K_RST: begin
                if (Req_Index != 3'd0) w_decode[w_rst_bit] = 1'b1;
            end
            default: w_decode = '0;
        endcase
    end

    always_comb begin
        w_daa_sel = '0;
        if (r_lo && w_hi_now)  w_daa_sel[10] = 1'b1;
        else if (w_hi_now)     w_daa_sel[13] = 1'b1;
        else if (r_lo)         w_daa_sel[12] = 1'b1;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sel_nxt    = r_sel;
        w_done_nxt   = 1'b0;
        w_carry_nxt  = r_daa_carry;
        w_lo_nxt     = r_lo;
        w_flag_c_nxt = r_flag_c;
        w_hi_nxt     = r_hi;
        case (r_state)
            IDLE: begin
                if (Req_Valid && Req_Ready) begin
                    w_lo_nxt     = Flag_H | Low_Nib_Gt9;
                    w_flag_c_nxt = Flag_C;
                    if (Req_Kind == K_DAA) begin
                        w_state_nxt   = DAA_CMP;
                        w_cnt_nxt     = CMP_LOAD;
                        w_sel_nxt     = '0;
                        w_sel_nxt[11] = 1'b1;
                    end else begin
                        w_state_nxt = DRIVE;
                        w_cnt_nxt   = HOLD_LOAD;
                        w_sel_nxt   = w_decode;
                    end
                end
            end
            DRIVE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = DONE;
                    w_sel_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            DAA_CMP: begin
                // Alu_Gt99 only matters on the last 0x99 cycle
                if (r_cnt == 4'd0) begin
                    w_state_nxt = DAA_DRIVE;
                    w_cnt_nxt   = HOLD_LOAD;
                    w_hi_nxt    = w_hi_now;
                    w_sel_nxt   = w_daa_sel;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            DAA_DRIVE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = DONE;
                    w_sel_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_carry_nxt = r_hi;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_sel       <= '0;
            r_done      <= 1'b0;
            r_daa_carry <= 1'b0;
            r_lo        <= 1'b0;
            r_flag_c    <= 1'b0;
            r_hi        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sel       <= w_sel_nxt;
            r_done      <= w_done_nxt;
            r_daa_carry <= w_carry_nxt;
            r_lo        <= w_lo_nxt;
            r_flag_c    <= w_flag_c_nxt;
            r_hi        <= w_hi_nxt;
        end
    end

endmodule

// File: tb/tb_alu_const_select_sequencer.sv
// Bench for alu_const_select_sequencer: two instances with different hold/compare timing, checked against a transaction model.
module tb_alu_const_select_sequencer;

    localparam int HA = 1, CA = 2;
    localparam int HB = 3, CB = 1;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESET_n, Req_Valid, use_b;
    logic [2:0]  Req_Kind, Req_Index;
    logic        Flag_H, Flag_C, Low_Nib_Gt9, Alu_Gt99;
    logic        vld_a, vld_b, rdy_a, rdy_b, done_a, done_b, car_a, car_b;
    logic [17:0] sel_a, sel_b;
    logic        rdy, done, car;
    logic [17:0] sel;

    assign vld_a = Req_Valid & ~use_b;
    assign vld_b = Req_Valid & use_b;
    assign rdy   = use_b ? rdy_b  : rdy_a;
    assign done  = use_b ? done_b : done_a;
    assign car   = use_b ? car_b  : car_a;
    assign sel   = use_b ? sel_b  : sel_a;

    alu_const_select_sequencer #(.HOLD_CYCLES(HA), .CMP_LATENCY(CA)) dut_a (
        .CLK(CLK), .RESET_n(RESET_n), .Req_Valid(vld_a), .Req_Ready(rdy_a),
        .Req_Kind(Req_Kind), .Req_Index(Req_Index), .Flag_H(Flag_H), .Flag_C(Flag_C),
        .Low_Nib_Gt9(Low_Nib_Gt9), .Alu_Gt99(Alu_Gt99), .Sel(sel_a), .Done(done_a),
        .Daa_Carry(car_a));

    alu_const_select_sequencer #(.HOLD_CYCLES(HB), .CMP_LATENCY(CB)) dut_b (
        .CLK(CLK), .RESET_n(RESET_n), .Req_Valid(vld_b), .Req_Ready(rdy_b),
        .Req_Kind(Req_Kind), .Req_Index(Req_Index), .Flag_H(Flag_H), .Flag_C(Flag_C),
        .Low_Nib_Gt9(Low_Nib_Gt9), .Alu_Gt99(Alu_Gt99), .Sel(sel_b), .Done(done_b),
        .Daa_Carry(car_b));

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_car[2];

    // Which select line carries a given constant value.
    function automatic logic [17:0] const_sel(input int value);
        logic [17:0] r;
        r = '0;
        case (value)
            1:       r[2]  = 1'b1;
            2:       r[14] = 1'b1;
            4:       r[15] = 1'b1;
            8:       r[3]  = 1'b1;
            16:      r[4]  = 1'b1;
            24:      r[5]  = 1'b1;
            32:      r[6]  = 1'b1;
            40:      r[7]  = 1'b1;
            48:      r[8]  = 1'b1;
            56:      r[9]  = 1'b1;
            64:      r[16] = 1'b1;
            128:     r[17] = 1'b1;
            'h06:    r[12] = 1'b1;
            'h60:    r[13] = 1'b1;
            'h66:    r[10] = 1'b1;
            'h99:    r[11] = 1'b1;
            'hFF00:  r[1]  = 1'b1;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Constant value requested by a non-DAA request.
    function automatic int const_of(input int kind, input int idx);
        case (kind)
            1:       return 1;
            2:       return 1 << idx;
            3:       return idx * 8;
            5:       return 'hFF00;
            default: return 0;
        endcase
    endfunction

    task automatic do_req(input bit b, input int kind, input int idx,
                          input bit h, input bit c, input bit n9, input bit g);
        int hold, cmp, lat, budget;
        bit lo, hi;
        logic [17:0] s1, s2, es;
        hold = b ? HB : HA;
        cmp  = b ? CB : CA;
        use_b = b;
        Req_Kind = 3'(kind); Req_Index = 3'(idx);
        Flag_H = h; Flag_C = c; Low_Nib_Gt9 = n9;
        Alu_Gt99 = 1'($urandom);
        Req_Valid = 1'b1;
        #1;
        budget = 0;
        while (rdy !== 1'b1 && budget < 40) begin
            @(negedge CLK); #1; budget++;
        end
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_wait: Req_Ready=%b, required 1 within 40 cycles", rdy);
        end
        @(posedge CLK); #1;
        Req_Valid = 1'b0;
        Req_Kind = 3'($urandom); Req_Index = 3'($urandom);
        Flag_H = 1'($urandom); Flag_C = 1'($urandom); Low_Nib_Gt9 = 1'($urandom);
        lo = h | n9;
        hi = c | g;
        if (kind == 4) begin
            s1  = const_sel('h99);
            s2  = const_sel((lo ? 'h06 : 0) + (hi ? 'h60 : 0));
            lat = cmp + hold;
        end else begin
            s1  = '0;
            s2  = const_sel(const_of(kind, idx));
            cmp = 0;
            lat = hold;
        end
        for (int i = 1; i <= lat + 2; i++) begin
            @(negedge CLK);
            Alu_Gt99 = (kind == 4 && i == cmp) ? g : 1'($urandom);
            if (i <= cmp)      es = s1;
            else if (i <= lat) es = s2;
            else               es = '0;
            if (i == lat + 1 && kind == 4) exp_car[b] = hi;
            n_cmp++;
            if (sel !== es) begin
                n_bad++;
                $display("FAIL sel k%0d i%0d dut%0d cyc%0d: got %h want %h", kind, idx, b, i, sel, es);
            end
            n_cmp++;
            if (done !== (i == lat + 1)) begin
                n_bad++;
                $display("FAIL done k%0d dut%0d cyc%0d: got %b want %b", kind, b, i, done, (i == lat + 1));
            end
            n_cmp++;
            if (rdy !== (i == lat + 2)) begin
                n_bad++;
                $display("FAIL ready k%0d dut%0d cyc%0d: got %b want %b", kind, b, i, rdy, (i == lat + 2));
            end
            n_cmp++;
            if (car !== exp_car[b]) begin
                n_bad++;
                $display("FAIL daa_carry k%0d dut%0d cyc%0d: got %b want %b", kind, b, i, car, exp_car[b]);
            end
        end
    endtask

    task automatic test_reset();
        RESET_n = 1'b0; use_b = 1'b0; Req_Valid = 1'b1; Req_Kind = 3'd1;
        repeat (3) begin
            @(negedge CLK);
            n_cmp++;
            if (sel_a !== 18'h0 || sel_b !== 18'h0) begin
                n_bad++; $display("FAIL reset_sel: got %h/%h want 0", sel_a, sel_b);
            end
            n_cmp++;
            if (done_a !== 1'b0 || done_b !== 1'b0 || rdy_a !== 1'b0 || rdy_b !== 1'b0) begin
                n_bad++; $display("FAIL reset_done_ready: done %b%b ready %b%b want 0", done_a, done_b, rdy_a, rdy_b);
            end
            n_cmp++;
            if (car_a !== 1'b0 || car_b !== 1'b0) begin
                n_bad++; $display("FAIL reset_carry: got %b%b want 0", car_a, car_b);
            end
        end
        RESET_n = 1'b1;
        #1;
        n_cmp++;
        if (rdy_a !== 1'b1) begin
            n_bad++; $display("FAIL ready_after_release: got %b want 1", rdy_a);
        end
        @(posedge CLK); #1;
        Req_Valid = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (sel_a !== 18'h00004) begin
            n_bad++; $display("FAIL accept_on_release: sel got %h want 00004", sel_a);
        end
        @(negedge CLK);
        n_cmp++;
        if (done_a !== 1'b1) begin
            n_bad++; $display("FAIL release_done: got %b want 1", done_a);
        end
        @(negedge CLK);
    endtask

    task automatic test_bitmask_sweep();
        for (int i = 0; i < 8; i++) do_req(1'b0, 2, i, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic test_rst_sweep();
        for (int i = 0; i < 8; i++) do_req(1'b1, 3, i, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic test_daa();
        do_req(1'b0, 4, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        do_req(1'b0, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_req(1'b1, 4, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_req(1'b1, 4, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        do_req(1'b0, 4, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_req(1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [17:0] es[6];
        bit ed[6], er[6];
        int dones;
        es = '{18'h00004, 18'h0, 18'h0, 18'h00002, 18'h0, 18'h0};
        ed = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        er = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        dones = 0;
        use_b = 1'b0; Req_Kind = 3'd1; Req_Valid = 1'b1;
        @(posedge CLK); #1;
        Req_Kind = 3'd5;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (i == 3) Req_Valid = 1'b0;
            if (done_a === 1'b1) dones++;
            n_cmp++;
            if (sel_a !== es[i]) begin
                n_bad++; $display("FAIL b2b_sel cyc%0d: got %h want %h", i + 1, sel_a, es[i]);
            end
            n_cmp++;
            if (done_a !== ed[i] || rdy_a !== er[i]) begin
                n_bad++; $display("FAIL b2b_done_ready cyc%0d: got %b%b want %b%b", i + 1, done_a, rdy_a, ed[i], er[i]);
            end
        end
        n_cmp++;
        if (dones != 2) begin
            n_bad++; $display("FAIL b2b_done_count: got %0d want 2", dones);
        end
    endtask

    task automatic test_reset_mid_daa();
        do_req(1'b0, 4, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        use_b = 1'b0; Req_Kind = 3'd4; Req_Valid = 1'b1;
        @(posedge CLK); #1;
        Req_Valid = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (sel_a !== 18'h00800) begin
            n_bad++; $display("FAIL mid_daa_cmp_sel: got %h want 00800", sel_a);
        end
        RESET_n = 1'b0;
        @(negedge CLK);
        exp_car[0] = 1'b0; exp_car[1] = 1'b0;
        n_cmp++;
        if (sel_a !== 18'h0 || done_a !== 1'b0 || car_a !== 1'b0) begin
            n_bad++; $display("FAIL mid_daa_reset: sel %h done %b carry %b want 0 0 0", sel_a, done_a, car_a);
        end
        RESET_n = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (done_a !== 1'b0 || rdy_a !== 1'b1) begin
            n_bad++; $display("FAIL mid_daa_after: done %b ready %b want 0 1", done_a, rdy_a);
        end
        do_req(1'b0, 4, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++)
            do_req(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        RESET_n = 1'b0; Req_Valid = 1'b0; use_b = 1'b0;
        Req_Kind = 3'd0; Req_Index = 3'd0;
        Flag_H = 1'b0; Flag_C = 1'b0; Low_Nib_Gt9 = 1'b0; Alu_Gt99 = 1'b0;
        exp_car[0] = 1'b0; exp_car[1] = 1'b0;
        test_reset();
        test_bitmask_sweep();
        test_rst_sweep();
        test_daa();
        test_back_to_back();
        test_reset_mid_daa();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
